// File: rtl/conv_encoder_tx.sv
// Rate-1/2 K=4 convolutional encoder with valid/ready framing.
// Ports: clk, rst (async active-low), enable (sync clear),
//   in_valid/in_ready/in_bit/in_last -> input bit stream,
//   out_valid/out_ready/d_out        -> coded symbol stream,
//   frame_done (final symbol accepted pulse), busy (frame active).
// Config macro: CONV_TAIL_FLUSH_EN appends 3 zero tail bits per frame.
module conv_encoder_tx #(
    parameter logic [3:0] G0        = 4'b1111,
    parameter logic [3:0] G1        = 4'b1101,
    parameter int         MAX_FRAME = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] d_out,
    output logic       frame_done,
    output logic       busy
);

    localparam int CW = $clog2(MAX_FRAME);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_TAIL,
        S_END
    } state_t;

`ifdef CONV_TAIL_FLUSH_EN
    localparam state_t TERM = S_TAIL;
`else
    localparam state_t TERM = S_END;
`endif

    state_t        state;
    logic [2:0]    s;
    logic [CW-1:0] bit_cnt;
    logic [1:0]    tail_cnt;

    logic load;
    logic accept;
    logic at_max;

    function automatic logic [1:0] enc(
        input logic       u,
        input logic [2:0] st
    );
        logic [3:0] v;
        v = {u, st};
        return {^(v & G0), ^(v & G1)};
    endfunction

    // Output register may take a new symbol when empty or draining.
    assign load   = !out_valid || out_ready;
    assign in_ready = enable && rst && load &&
                      (state == S_IDLE || state == S_DATA);
    assign accept = in_valid && in_ready;
    // Accepting this bit fills the frame to MAX_FRAME.
    assign at_max = (({1'b0, bit_cnt} + 1'b1) ==
                     (CW+1)'(MAX_FRAME));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            s          <= 3'b000;
            bit_cnt    <= '0;
            tail_cnt   <= 2'd0;
            out_valid  <= 1'b0;
            d_out      <= 2'b00;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else if (!enable) begin
            state      <= S_IDLE;
            s          <= 3'b000;
            bit_cnt    <= '0;
            tail_cnt   <= 2'd0;
            out_valid  <= 1'b0;
            d_out      <= 2'b00;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (load) begin
                if (accept) begin
                    out_valid <= 1'b1;
                    d_out     <= enc(in_bit, s);
                    s         <= {in_bit, s[2:1]};
                end else if (state == S_TAIL) begin
                    out_valid <= 1'b1;
                    d_out     <= enc(1'b0, s);
                    s         <= {1'b0, s[2:1]};
                end else begin
                    out_valid <= 1'b0;
                end
            end

            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        busy    <= 1'b1;
                        bit_cnt <= CW'(1);
                        state   <= in_last ? TERM : S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        // Hold the count at the frame limit so it never wraps.
                        if (!at_max)
                            bit_cnt <= bit_cnt + 1'b1;
                        if (in_last || at_max)
                            state <= TERM;
                    end
                end
                S_TAIL: begin
                    if (load) begin
                        if (tail_cnt == 2'd2) begin
                            tail_cnt <= 2'd0;
                            state    <= S_END;
                        end else begin
                            tail_cnt <= tail_cnt + 2'd1;
                        end
                    end
                end
                S_END: begin
                    if (out_valid && out_ready) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        s          <= 3'b000;
                        bit_cnt    <= '0;
                        state      <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Directed bench for conv_encoder_tx: framed vectors,
// backpressure, forced termination, abort and async reset.
module tb_conv_encoder_tx;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] d_out;
    logic       frame_done;
    logic       busy;

    conv_encoder_tx dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bit     (in_bit),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .d_out      (d_out),
        .frame_done (frame_done),
        .busy       (busy)
    );

`ifdef CONV_TAIL_FLUSH_EN
    localparam bit TAIL_EN = 1'b1;
`else
    localparam bit TAIL_EN = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 0: always ready, 1: ready 2 of 3 cycles, 2: never ready
    int ready_mode = 0;
    int cyc = 0;
    always @(posedge clk) #1 cyc = cyc + 1;
    always_comb begin
        out_ready = 1'b1;
        case (ready_mode)
            1: out_ready = (cyc % 3) != 0;
            2: out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    logic [1:0] q[$];
    int fd_cnt = 0;
    int done_len = 0;
    always @(negedge clk) begin
        if (out_valid && out_ready)
            q.push_back(d_out);
        if (frame_done) begin
            fd_cnt = fd_cnt + 1;
            done_len = q.size();
        end
    end

    typedef struct {
        int         frame;
        logic       u;
        logic       last;
        logic       tail;
        logic [1:0] sym;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int f, input logic u,
                       input logic l, input logic t,
                       input logic [1:0] sy);
        vec_t v;
        v.frame = f;
        v.u = u;
        v.last = l;
        v.tail = t;
        v.sym = sy;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h",
                     nm, act, exp);
        end
    endtask

    task automatic drive_bit(input logic u, input logic l);
        int t;
        in_valid = 1'b1;
        in_bit = u;
        in_last = l;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 3000) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL accept_timeout actual=0 required=1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done(input int base);
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk);
            if (fd_cnt > base) break;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("frame_done_count", fd_cnt - base, 1);
    endtask

    task automatic check_frame(input int f, input int base);
        logic [1:0] e[$];
        int n;
        e.delete();
        foreach (tbl[i])
            if (tbl[i].frame == f && (!tbl[i].tail || TAIL_EN))
                e.push_back(tbl[i].sym);
        wait_done(base);
        chk($sformatf("f%0d_nsym", f), q.size(), e.size());
        chk($sformatf("f%0d_done_at", f), done_len, e.size());
        n = (q.size() < e.size()) ? q.size() : e.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("f%0d_sym%0d", f, i), q[i], e[i]);
        chk($sformatf("f%0d_state0", f), dut.s, 0);
        chk($sformatf("f%0d_busy", f), busy, 0);
    endtask

    task automatic run_frame(input int f);
        int base;
        q.delete();
        base = fd_cnt;
        foreach (tbl[i])
            if (tbl[i].frame == f && !tbl[i].tail)
                drive_bit(tbl[i].u, tbl[i].last);
        check_frame(f, base);
    endtask

    int base;
    logic [1:0] held;

    initial begin
        add(0, 1, 0, 0, 2'b11);
        add(0, 0, 0, 0, 2'b11);
        add(0, 1, 0, 0, 2'b01);
        add(0, 1, 1, 0, 2'b11);
        add(0, 0, 0, 1, 2'b01);
        add(0, 0, 0, 1, 2'b01);
        add(0, 0, 0, 1, 2'b11);
        add(1, 1, 1, 0, 2'b11);
        add(1, 0, 0, 1, 2'b11);
        add(1, 0, 0, 1, 2'b10);
        add(1, 0, 0, 1, 2'b11);
        add(2, 0, 0, 0, 2'b00);
        add(2, 0, 0, 0, 2'b00);
        add(2, 1, 0, 0, 2'b11);
        add(2, 0, 1, 0, 2'b11);
        add(2, 0, 0, 1, 2'b10);
        add(2, 0, 0, 1, 2'b11);
        add(2, 0, 0, 1, 2'b00);
        add(3, 1, 0, 0, 2'b11);
        add(3, 1, 0, 0, 2'b00);
        add(3, 1, 0, 0, 2'b10);
        add(3, 0, 0, 0, 2'b10);
        add(3, 1, 1, 0, 2'b10);
        add(3, 0, 0, 1, 2'b00);
        add(3, 0, 0, 1, 2'b10);
        add(3, 0, 0, 1, 2'b11);

        rst = 1'b0;
        enable = 1'b0;
        in_valid = 1'b0;
        in_bit = 1'b0;
        in_last = 1'b0;
        #23;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_d_out", d_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("dis_in_ready", in_ready, 0);
        enable = 1'b1;
        #1;
        chk("en_in_ready", in_ready, 1);

        for (int m = 0; m < 2; m++) begin
            ready_mode = m;
            for (int f = 0; f < 4; f++)
                run_frame(f);
        end
        ready_mode = 0;

        // Backpressure mid-frame.
        q.delete();
        base = fd_cnt;
        drive_bit(1, 0);
        drive_bit(0, 0);
        ready_mode = 2;
        in_valid = 1'b1;
        in_bit = 1'b1;
        in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_d_out", d_out, 2'b11);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        ready_mode = 0;
        drive_bit(1, 0);
        drive_bit(1, 1);
        check_frame(0, base);

        // Forced termination at the frame limit.
        q.delete();
        base = fd_cnt;
        for (int i = 0; i < 1024; i++)
            drive_bit(i[0], 1'b0);
        @(negedge clk);
        chk("max_in_ready", in_ready, 0);
        chk("max_busy", busy, 1);
        wait_done(base);
        chk("max_nsym", q.size(), TAIL_EN ? 1027 : 1024);
        chk("max_busy_after", busy, 0);
        run_frame(1);

        // Abort mid-tail with enable low.
        drive_bit(1, 0);
        drive_bit(1, 1);
        base = fd_cnt;
        enable = 1'b0;
        #1;
        chk("abort_in_ready_now", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_state0", dut.s, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_done", fd_cnt - base, 0);
        enable = 1'b1;
        run_frame(1);

        // Asynchronous reset while a symbol is held.
        drive_bit(1, 0);
        ready_mode = 2;
        @(negedge clk);
        held = d_out;
        chk("ar_pre_valid", out_valid, 1);
        chk("ar_pre_d_out", held, 2'b11);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_d_out", d_out, 0);
        chk("ar_busy", busy, 0);
        chk("ar_frame_done", frame_done, 0);
        chk("ar_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        ready_mode = 0;
        run_frame(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=done");
        $fatal(1);
    end

endmodule
